// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer_if
// Purpose  : Decode/ALU <-> PC sequencer signal bundle.
// Revision : 1.0  initial release
// ============================================================================
interface pc_sequencer_if;
    logic        imem_ready;
    logic        stall;
    logic        is_branch;
    logic        is_br;
    logic [2:0]  cond;
    logic [8:0]  imm;
    logic [15:0] rs_val;
    logic        is_hlt;
    logic [2:0]  flag_we;
    logic [2:0]  flag_in;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic [2:0]  flags;
    logic        taken;
    logic        fetch_req;
    logic        commit;
    logic        halted;

    modport slave (
        input  imem_ready, stall, is_branch, is_br, cond, imm, rs_val,
               is_hlt, flag_we, flag_in,
        output pc, pc_plus2, flags, taken, fetch_req, commit, halted
    );

    modport master (
        output imem_ready, stall, is_branch, is_br, cond, imm, rs_val,
               is_hlt, flag_we, flag_in,
        input  pc, pc_plus2, flags, taken, fetch_req, commit, halted
    );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Architectural PC and N/Z/V flag owner; branch resolution and
//            boot / wait / stall / halt sequencing for the single-cycle core.
// Revision : 1.0  initial release
// ============================================================================
module pc_sequencer #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int          BOOT_CYCLES = 1
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [3:0] C_BOOT_LAST = 4'(BOOT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [2:0]  flags_q, flags_d;
    logic [3:0]  boot_cnt_q, boot_cnt_d;

    logic [15:0] pc_plus2;
    logic [15:0] b_target;
    logic [15:0] next_pc;
    logic        cond_true;
    logic        commit;
    logic        taken;
    logic        flag_n, flag_z, flag_v;

    assign flag_n = flags_q[0];
    assign flag_z = flags_q[1];
    assign flag_v = flags_q[2];

    assign pc_plus2 = pc_q + 16'd2;
    // Word offset scaled to bytes; modulo-2^16 wrap is intentional.
    assign b_target = pc_plus2 + {{6{bus.imm[8]}}, bus.imm, 1'b0};

    // Decisions use the registered flags only, never this cycle's flag_in.
    always_comb begin
        cond_true = 1'b0;
        case (bus.cond)
            3'b000: cond_true = ~flag_z;
            3'b001: cond_true = flag_z;
            3'b010: cond_true = ~flag_z & ~flag_n;
            3'b011: cond_true = flag_n;
            3'b100: cond_true = flag_z | (~flag_z & ~flag_n);
            3'b101: cond_true = flag_n | flag_z;
            3'b110: cond_true = flag_v;
            3'b111: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    assign commit = (state_q == ST_RUN) & bus.imem_ready & ~bus.stall;
    assign taken  = commit & (bus.is_branch | bus.is_br) & cond_true & ~bus.is_hlt;

    always_comb begin
        next_pc = pc_plus2;
        if (taken) begin
            if (bus.is_br)
                next_pc = bus.rs_val & 16'hFFFE;
            else
                next_pc = b_target;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        flags_d    = flags_q;
        boot_cnt_d = boot_cnt_q;
        case (state_q)
            ST_BOOT: begin
                if (boot_cnt_q == C_BOOT_LAST)
                    state_d = ST_RUN;
                else
                    boot_cnt_d = boot_cnt_q + 4'd1;
            end
            ST_RUN: begin
                if (commit) begin
                    flags_d = (flags_q & ~bus.flag_we) | (bus.flag_in & bus.flag_we);
                    if (bus.is_hlt)
                        state_d = ST_HALT;
                    else
                        pc_d = next_pc;
                end
            end
            ST_HALT: begin
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            flags_q    <= 3'b000;
            boot_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            flags_q    <= flags_d;
            boot_cnt_q <= boot_cnt_d;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.pc_plus2  = pc_plus2;
    assign bus.flags     = flags_q;
    assign bus.taken     = taken;
    assign bus.commit    = commit;
    assign bus.fetch_req = (state_q != ST_HALT);
    assign bus.halted    = (state_q == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Self-checking scoreboard bench for pc_sequencer.
// Revision : 1.0  initial release
// ============================================================================
module tb_pc_sequencer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pc_sequencer_if bus();

    pc_sequencer #(
        .RESET_PC    (16'h0000),
        .BOOT_CYCLES (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        string       tag;
        logic [15:0] pc;
        logic [2:0]  flags;
        logic        halted;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %04h expected %04h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [15:0] pc,
                            input logic [2:0] flags, input logic halted);
        exp_t e;
        e.tag    = tag;
        e.pc     = pc;
        e.flags  = flags;
        e.halted = halted;
        sb_q.push_back(e);
    endtask

    // Advance one edge, then retire every pending expectation against the DUT.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({e.tag, ".pc"},     bus.pc,               e.pc);
            chk({e.tag, ".flags"},  16'(bus.flags),       16'(e.flags));
            chk({e.tag, ".halted"}, 16'(bus.halted),      16'(e.halted));
        end
    endtask

    task automatic set_in(input logic ready, input logic stl, input logic isb,
                          input logic isbr, input logic [2:0] cnd, input logic [8:0] im,
                          input logic [15:0] rs, input logic hlt,
                          input logic [2:0] fwe, input logic [2:0] fin);
        bus.imem_ready = ready;
        bus.stall      = stl;
        bus.is_branch  = isb;
        bus.is_br      = isbr;
        bus.cond       = cnd;
        bus.imm        = im;
        bus.rs_val     = rs;
        bus.is_hlt     = hlt;
        bus.flag_we    = fwe;
        bus.flag_in    = fin;
    endtask

    task automatic seq_in();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 9'd0, 16'h0000, 1'b0, 3'b000, 3'b000);
    endtask

    task automatic br_in(input logic [15:0] target);
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 3'b111, 9'd0, target, 1'b0, 3'b000, 3'b000);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 9'd0, 16'h0000, 1'b0, 3'b000, 3'b000);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.pc",        bus.pc,                16'h0000);
        chk("rst.flags",     16'(bus.flags),        16'h0000);
        chk("rst.halted",    16'(bus.halted),       16'h0000);
        chk("rst.fetch_req", 16'(bus.fetch_req),    16'h0001);

        // Boot: one edge with no commit, then sequential fetch
        rst = 1'b0;
        seq_in();
        #1;
        chk("boot.commit", 16'(bus.commit), 16'h0000);
        push_exp("boot", 16'h0000, 3'b000, 1'b0);
        tick();
        chk("run.commit", 16'(bus.commit), 16'h0001);
        chk("run.pc_plus2", bus.pc_plus2, 16'h0002);
        push_exp("seq1", 16'h0002, 3'b000, 1'b0); tick();
        push_exp("seq2", 16'h0004, 3'b000, 1'b0); tick();

        set_in(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 9'd0, 16'h0000, 1'b0, 3'b111, 3'b101);
        push_exp("flagset", 16'h0006, 3'b101, 1'b0); tick();
        br_in(16'h0041);
        #1;
        chk("br40.taken", 16'(bus.taken), 16'h0001);
        push_exp("br40", 16'h0040, 3'b101, 1'b0); tick();

        // Asynchronous reset mid-cycle
        #2;
        rst = 1'b1;
        #1;
        chk("arst.pc",     bus.pc,            16'h0000);
        chk("arst.flags",  16'(bus.flags),    16'h0000);
        chk("arst.commit", 16'(bus.commit),   16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reboot.commit", 16'(bus.commit), 16'h0000);
        push_exp("reboot", 16'h0000, 3'b000, 1'b0); tick();

        // Conditional B, not taken then taken
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 9'd0, 16'h0000, 1'b0, 3'b010, 3'b010);
        push_exp("setz", 16'h0002, 3'b010, 1'b0); tick();
        br_in(16'h0010);
        push_exp("br10a", 16'h0010, 3'b010, 1'b0); tick();
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 9'h004, 16'h0000, 1'b0, 3'b000, 3'b000);
        #1;
        chk("bnz.taken", 16'(bus.taken), 16'h0000);
        push_exp("bnz", 16'h0012, 3'b010, 1'b0); tick();
        br_in(16'h0010);
        push_exp("br10b", 16'h0010, 3'b010, 1'b0); tick();
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 3'b001, 9'h004, 16'h0000, 1'b0, 3'b000, 3'b000);
        #1;
        chk("bz.taken", 16'(bus.taken), 16'h0001);
        push_exp("bz", 16'h0012 + 16'h0008, 3'b010, 1'b0); tick();

        // Negative offset wrapping below zero, then sequential wrap
        br_in(16'h0004);
        push_exp("br04", 16'h0004, 3'b010, 1'b0); tick();
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 3'b111, 9'h1FC, 16'h0000, 1'b0, 3'b000, 3'b000);
        push_exp("bneg", 16'hFFFE, 3'b010, 1'b0); tick();
        seq_in();
        push_exp("wrap", 16'h0000, 3'b010, 1'b0); tick();

        // Flag write in the same cycle as BR must not steer that BR
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 3'b011, 9'd0, 16'h1235, 1'b0, 3'b001, 3'b001);
        #1;
        chk("brn1.taken", 16'(bus.taken), 16'h0000);
        push_exp("brn1", 16'h0002, 3'b011, 1'b0); tick();
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 3'b011, 9'd0, 16'h1235, 1'b0, 3'b000, 3'b000);
        #1;
        chk("brn2.taken", 16'(bus.taken), 16'h0001);
        push_exp("brn2", 16'h1234, 3'b011, 1'b0); tick();

        // Memory wait then decode stall: nothing may change
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 3'b111, 9'd0, 16'h5555, 1'b0, 3'b111, 3'b100);
        for (int i = 0; i < 5; i++) begin
            if (i == 3) begin
                bus.imem_ready = 1'b1;
                bus.stall      = 1'b1;
            end
            #1;
            chk("hold.commit", 16'(bus.commit), 16'h0000);
            chk("hold.taken",  16'(bus.taken),  16'h0000);
            push_exp("hold", 16'h1234, 3'b011, 1'b0); tick();
        end
        bus.stall = 1'b0;
        #1;
        chk("release.commit", 16'(bus.commit), 16'h0001);
        push_exp("release", 16'h5554, 3'b100, 1'b0); tick();
        seq_in();
        push_exp("after", 16'h5556, 3'b100, 1'b0); tick();

        // Stalled HLT must not halt
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 9'd0, 16'h0000, 1'b1, 3'b111, 3'b111);
        push_exp("stallhlt", 16'h5556, 3'b100, 1'b0); tick();

        // Halt, then frozen under random input activity
        br_in(16'h0020);
        push_exp("br20", 16'h0020, 3'b100, 1'b0); tick();
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 3'b111, 9'd0, 16'h0100, 1'b1, 3'b111, 3'b010);
        #1;
        chk("hlt.taken", 16'(bus.taken), 16'h0000);
        push_exp("hlt", 16'h0020, 3'b010, 1'b1); tick();
        chk("hlt.fetch_req", 16'(bus.fetch_req), 16'h0000);
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, 1'b0, 1'($urandom), 1'($urandom), 3'($urandom), 9'($urandom),
                   16'($urandom), 1'($urandom), 3'b111, 3'($urandom));
            #1;
            chk("frozen.commit",    16'(bus.commit),    16'h0000);
            chk("frozen.taken",     16'(bus.taken),     16'h0000);
            chk("frozen.fetch_req", 16'(bus.fetch_req), 16'h0000);
            push_exp("frozen", 16'h0020, 3'b010, 1'b1); tick();
        end

        rst = 1'b1;
        #1;
        chk("unhalt.pc",        bus.pc,             16'h0000);
        chk("unhalt.halted",    16'(bus.halted),    16'h0000);
        chk("unhalt.fetch_req", 16'(bus.fetch_req), 16'h0001);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
